counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Shares one CNT_W-bit interval counter between NUM_REQ requesters.
- Each requester raises req with a duration value.
- The block grants the counter to one requester at a time using round-robin arbitration.
- It runs the counter for that duration, then pulses done to the owner and releases the counter.
- It sits between client blocks needing timed windows and the shared counter datapath; count is exported for observation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 7, counter and duration width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- dur  input  NUM_REQ*CNT_W  per-requester duration; requester i uses bits [i*CNT_W +: CNT_W].
- gnt  output  NUM_REQ  one-hot grant, high for the whole window.
- owner  output  max(1,$clog2(NUM_REQ))  index of the current or most recent owner.
- busy  output  1  high in GRANT and RELEASE states.
- count  output  CNT_W  shared counter value.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.
- abort  output  1  one-cycle pulse when a window ends early.

Behaviour:
- Reset: applied on any clock edge with rst=1, including mid-window. All outputs go to 0 (gnt=0, done=0, abort=0, count=0, busy=0, owner=0). State goes to IDLE. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset. No done or abort pulse is emitted for a window killed by reset.
- IDLE:
  - Taken when any req bit is 1 at the clock edge.
  - Winner is the first set req index searching last+1, last+2, ... (mod NUM_REQ).
  - Register gnt=onehot(winner), owner=winner, dur_l=dur[winner] (latched; later dur changes ignored), count=0.
  - Go to GRANT.
  - Latency: req sampled at edge E, gnt visible after edge E.
- GRANT:
  - count increments by 1 each cycle.
  - Window length L = dur_l, except dur_l=0 is treated as L=1.
  - gnt is held for exactly L cycles; count shows 0..L-1.
  - On the edge where count==L-1: go to RELEASE, gnt=0, done[owner]=1, last=owner, count=0.
  - Max window is 2^CNT_W-1 cycles (127 at default); count never wraps.
- Early drop:
  - If req[owner]=0 is sampled in GRANT (before the final cycle), go to RELEASE with abort=1, done=0, gnt=0, last=owner, count=0.
  - On the final cycle, normal completion wins over abort.
- RELEASE:
  - One cycle, busy=1, gnt=0; done or abort high for this cycle only.
  - Then go to IDLE; a new arbitration takes place on the IDLE edge.
  - Minimum gap between back-to-back grants: 2 idle-grant cycles (RELEASE + IDLE).
- Other requesters' req changes during a window are ignored until IDLE.
- A requester holding req after its done is re-eligible; round-robin guarantees other pending requesters are served first.
- gnt is always one-hot or zero; done is one-hot or zero; done and abort never both high.

Optional Feature:
- Macro: COUNTER_ARB_FIXED_PRI_EN.
- Defined: arbitration is fixed priority, lowest set req index wins. The last pointer is not used.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset then single request: rst 1 for 2 cycles, then req=4'b0001 with dur0=5. Expect gnt=0001 for exactly 5 cycles with count 0..4, then done=0001 for 1 cycle, count=0, busy=0 afterwards.
- Round-robin: req=4'b1111 held, all dur=3. Expect grant order 0,1,2,3,0. Each window is 3 cycles with a 2-cycle gap; one done pulse per window to the matching bit.
- Abort: req=0010, dur1=10; drop req1 after the 4th grant cycle. Expect abort=1 for 1 cycle, done=0, gnt=0, count=0, then IDLE.
- Boundary durations: dur=0 gives a 1-cycle window; dur=127 gives a 127-cycle window ending with count=126 and no wrap. Changing dur mid-window does not alter the length.
- Reset mid-window: assert rst during count=20 of a 50-cycle window. Next cycle all outputs are 0, no done or abort pulse. With req=1111 after reset, requester 0 is granted first.
- COUNTER_ARB_FIXED_PRI_EN build: req=1111 held. Expect requester 0 granted repeatedly; req=1100 gives requester 2 repeatedly.

Source files
------------

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter sharing one interval counter among NUM_REQ requesters.
// Define COUNTER_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] dur,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [(($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
  output logic                     busy,
  output logic [CNT_W-1:0]         count,
  output logic [NUM_REQ-1:0]       done,
  output logic                     abort
);
  localparam int OW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] gnt_n, done_n;
  logic [OW-1:0] owner_n, win;
  logic [CNT_W-1:0] count_n, dur_l, dur_l_n, last_cnt;
  logic abort_n;
`ifndef COUNTER_ARB_FIXED_PRI_EN
  logic [OW-1:0] last, last_n;
`endif
  assign busy = state != IDLE;
  // A zero duration still gets a one-cycle window
  assign last_cnt = (dur_l == '0) ? '0 : dur_l - 1'b1;
  always_comb begin
    win = '0;
`ifdef COUNTER_ARB_FIXED_PRI_EN
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[k]) win = OW'(k);
`else
    // Scan downwards so the nearest index after last is assigned last and wins
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(last) + k) % NUM_REQ]) win = OW'((int'(last) + k) % NUM_REQ);
`endif
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    owner_n = owner;
    dur_l_n = dur_l;
    count_n = count;
    done_n = '0;
    abort_n = 1'b0;
`ifndef COUNTER_ARB_FIXED_PRI_EN
    last_n = last;
`endif
    case (state)
      IDLE: if (|req) begin
        state_n = GRANT;
        gnt_n = NUM_REQ'(1) << win;
        owner_n = win;
        dur_l_n = dur[int'(win)*CNT_W +: CNT_W];
        count_n = '0;
      end
      GRANT: begin
        if (count == last_cnt || !req[owner]) begin
          state_n = RELEASE;
          gnt_n = '0;
          count_n = '0;
          done_n = (count == last_cnt) ? gnt : '0;
          abort_n = count != last_cnt;
`ifndef COUNTER_ARB_FIXED_PRI_EN
          last_n = owner;
`endif
        end else
          count_n = count + 1'b1;
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      dur_l <= '0;
      count <= '0;
      done <= '0;
      abort <= 1'b0;
`ifndef COUNTER_ARB_FIXED_PRI_EN
      last <= OW'(NUM_REQ - 1);
`endif
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      owner <= owner_n;
      dur_l <= dur_l_n;
      count <= count_n;
      done <= done_n;
      abort <= abort_n;
`ifndef COUNTER_ARB_FIXED_PRI_EN
      last <= last_n;
`endif
    end
  end
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed and random stimulus checked each cycle against a window-level reference model.
module tb_counter_arbiter;
  localparam int N = 4, W = 7;
  logic clk = 1'b0, rst;
  logic [N-1:0] req, gnt, done;
  logic [N*W-1:0] dur;
  logic [1:0] owner;
  logic busy, abort;
  logic [W-1:0] count;
  int n_chk = 0, n_err = 0;
  int ph, cnt, len, own, last;
  logic [N-1:0] m_done;
  logic m_abort;
  int run, last_len, max_cnt;
  logic [N-1:0] prev_gnt;
  int order[$];

  counter_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur), .gnt(gnt), .owner(owner),
    .busy(busy), .count(count), .done(done), .abort(abort));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int l);
`ifdef COUNTER_ARB_FIXED_PRI_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
`endif
    return 0;
  endfunction

  // ph: 0 idle, 1 inside a window, 2 release cycle
  task automatic model_step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    m_done = '0;
    m_abort = 1'b0;
    if (r) begin
      ph = 0; cnt = 0; own = 0; last = N - 1;
    end else if (ph == 0) begin
      if (q != 0) begin
        own = pick(q, last);
        len = int'(d[own*W +: W]);
        if (len == 0) len = 1;
        cnt = 0;
        ph = 1;
      end
    end else if (ph == 1) begin
      if (cnt == len - 1) begin
        ph = 2; m_done[own] = 1'b1; last = own; cnt = 0;
      end else if (!q[own]) begin
        ph = 2; m_abort = 1'b1; last = own; cnt = 0;
      end else cnt++;
    end else ph = 0;
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    rst = r; req = q; dur = d;
    model_step(r, q, d);
    @(negedge clk);
    chk("gnt", 32'(gnt), (ph == 1) ? 32'(1) << own : 32'd0);
    chk("owner", 32'(owner), 32'(own));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("count", 32'(count), 32'(cnt));
    chk("done", 32'(done), 32'(m_done));
    chk("abort", 32'(abort), 32'(m_abort));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("done_and_abort", 32'(done != 0 && abort), 32'd0);
    if (gnt != 0) begin
      run++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end else if (run != 0) begin
      last_len = run;
      run = 0;
    end
    if (gnt != 0 && prev_gnt == 0) order.push_back(int'(owner));
    prev_gnt = gnt;
  endtask

  task automatic check_order(input string tag, input int e0, input int e1, input int e2);
    chk({tag, "_len"}, 32'(order.size() >= 3), 32'd1);
    if (order.size() >= 3) begin
      chk({tag, "0"}, 32'(order[0]), 32'(e0));
      chk({tag, "1"}, 32'(order[1]), 32'(e1));
      chk({tag, "2"}, 32'(order[2]), 32'(e2));
    end
  endtask

  initial begin
    logic [N*W-1:0] d;
    run = 0; last_len = 0; max_cnt = 0; prev_gnt = '0;
    ph = 0; cnt = 0; own = 0; last = N - 1; len = 1;
    // reset then a single 5-cycle window; req drops on the final cycle
    cyc(1, 0, 0); cyc(1, 0, 0);
    chk("rst_gnt", 32'(gnt), 0); chk("rst_busy", 32'(busy), 0);
    d = {4{7'd5}};
    for (int i = 0; i < 5; i++) cyc(0, 4'b0001, d);
    cyc(0, 4'b0000, d);
    chk("single_done", 32'(done), 32'b0001);
    chk("single_len", 32'(last_len), 5);
    cyc(0, 0, d);
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_count", 32'(count), 0);
    // all requesting, dur=3
    cyc(1, 0, 0); order.delete();
    for (int i = 0; i < 26; i++) cyc(0, 4'b1111, {4{7'd3}});
`ifdef COUNTER_ARB_FIXED_PRI_EN
    check_order("all_order", 0, 0, 0);
    if (order.size() >= 5) chk("all_order4", 32'(order[4]), 0);
`else
    check_order("all_order", 0, 1, 2);
    if (order.size() >= 5) begin
      chk("all_order3", 32'(order[3]), 3);
      chk("all_order4", 32'(order[4]), 0);
    end
`endif
    chk("all_len", 32'(last_len), 3);
    // upper requesters only
    cyc(1, 0, 0); order.delete();
    for (int i = 0; i < 16; i++) cyc(0, 4'b1100, {4{7'd2}});
`ifdef COUNTER_ARB_FIXED_PRI_EN
    check_order("hi_order", 2, 2, 2);
`else
    check_order("hi_order", 2, 3, 2);
`endif
    // early drop after four grant cycles
    cyc(1, 0, 0);
    d = {4{7'd10}};
    for (int i = 0; i < 4; i++) cyc(0, 4'b0010, d);
    cyc(0, 0, d);
    chk("abort_pulse", 32'(abort), 1);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_count", 32'(count), 0);
    cyc(0, 0, d);
    chk("abort_idle", 32'(busy), 0);
    // zero duration gives one cycle
    cyc(0, 4'b0001, 0); cyc(0, 0, 0);
    chk("dur0_done", 32'(done), 1);
    chk("dur0_len", 32'(last_len), 1);
    cyc(0, 0, 0);
    // maximum duration, dur changed mid-window
    max_cnt = 0;
    cyc(0, 4'b0001, {4{7'd127}});
    for (int i = 0; i < 126; i++) cyc(0, 4'b0001, {4{7'd3}});
    cyc(0, 0, 0);
    chk("max_done", 32'(done), 1);
    chk("max_len", 32'(last_len), 127);
    chk("max_cnt", 32'(max_cnt), 126);
    cyc(0, 0, 0);
    // reset in the middle of a 50-cycle window
    for (int i = 0; i < 21; i++) cyc(0, 4'b0001, {4{7'd50}});
    chk("mid_count", 32'(count), 20);
    cyc(1, 4'b0001, {4{7'd50}});
    chk("mid_rst_all", 32'({gnt, owner, busy, count, done, abort}), 0);
    cyc(0, 4'b1111, {4{7'd4}});
    chk("mid_rst_first", 32'(gnt), 32'b0001);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] q;
      q = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 3) == 0) q = '0;
      for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, N - 1)*W +: W] = W'($urandom);
      cyc($urandom_range(0, 199) == 0, q, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
